// File: rtl/ps2_pkg.sv
// Shared scancode, ASCII and prefix-state definitions for the PS/2 keycode path.
package ps2_pkg;

  // Set-2 prefix and modifier scancodes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  // ASCII control characters
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  // Prefix tracking: plain, after F0, after E0, after E0 F0
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// Combinational Set-2 make-code to ASCII translator (non-extended codes only).
module ps2_set2_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       hit
);

  // Letters take upper case when exactly one of shift/caps is active
  function automatic logic [7:0] letter(input logic [7:0] lower, input logic up);
    return up ? (lower & 8'hDF) : lower;
  endfunction

  // Digits and punctuation follow shift alone
  function automatic logic [7:0] pick(input logic [7:0] lo, input logic [7:0] hi,
                                      input logic sh);
    return sh ? hi : lo;
  endfunction

  logic up;
  assign up = shift ^ caps;

  // Table lookup; unmapped codes leave hit low
  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    case (code)
      8'h1C: ascii = letter(8'h61, up);  // a
      8'h32: ascii = letter(8'h62, up);  // b
      8'h21: ascii = letter(8'h63, up);  // c
      8'h23: ascii = letter(8'h64, up);  // d
      8'h24: ascii = letter(8'h65, up);  // e
      8'h2B: ascii = letter(8'h66, up);  // f
      8'h34: ascii = letter(8'h67, up);  // g
      8'h33: ascii = letter(8'h68, up);  // h
      8'h43: ascii = letter(8'h69, up);  // i
      8'h3B: ascii = letter(8'h6A, up);  // j
      8'h42: ascii = letter(8'h6B, up);  // k
      8'h4B: ascii = letter(8'h6C, up);  // l
      8'h3A: ascii = letter(8'h6D, up);  // m
      8'h31: ascii = letter(8'h6E, up);  // n
      8'h44: ascii = letter(8'h6F, up);  // o
      8'h4D: ascii = letter(8'h70, up);  // p
      8'h15: ascii = letter(8'h71, up);  // q
      8'h2D: ascii = letter(8'h72, up);  // r
      8'h1B: ascii = letter(8'h73, up);  // s
      8'h2C: ascii = letter(8'h74, up);  // t
      8'h3C: ascii = letter(8'h75, up);  // u
      8'h2A: ascii = letter(8'h76, up);  // v
      8'h1D: ascii = letter(8'h77, up);  // w
      8'h22: ascii = letter(8'h78, up);  // x
      8'h35: ascii = letter(8'h79, up);  // y
      8'h1A: ascii = letter(8'h7A, up);  // z
      8'h16: ascii = pick(8'h31, 8'h21, shift);  // 1 !
      8'h1E: ascii = pick(8'h32, 8'h40, shift);  // 2 @
      8'h26: ascii = pick(8'h33, 8'h23, shift);  // 3 #
      8'h25: ascii = pick(8'h34, 8'h24, shift);  // 4 $
      8'h2E: ascii = pick(8'h35, 8'h25, shift);  // 5 %
      8'h36: ascii = pick(8'h36, 8'h5E, shift);  // 6 ^
      8'h3D: ascii = pick(8'h37, 8'h26, shift);  // 7 &
      8'h3E: ascii = pick(8'h38, 8'h2A, shift);  // 8 *
      8'h46: ascii = pick(8'h39, 8'h28, shift);  // 9 (
      8'h45: ascii = pick(8'h30, 8'h29, shift);  // 0 )
      8'h0E: ascii = pick(8'h60, 8'h7E, shift);  // ` ~
      8'h4E: ascii = pick(8'h2D, 8'h5F, shift);  // - _
      8'h55: ascii = pick(8'h3D, 8'h2B, shift);  // = +
      8'h54: ascii = pick(8'h5B, 8'h7B, shift);  // [ {
      8'h5B: ascii = pick(8'h5D, 8'h7D, shift);  // ] }
      8'h5D: ascii = pick(8'h5C, 8'h7C, shift);  // \ |
      8'h4C: ascii = pick(8'h3B, 8'h3A, shift);  // ; :
      8'h52: ascii = pick(8'h27, 8'h22, shift);  // ' "
      8'h41: ascii = pick(8'h2C, 8'h3C, shift);  // , <
      8'h49: ascii = pick(8'h2E, 8'h3E, shift);  // . >
      8'h4A: ascii = pick(8'h2F, 8'h3F, shift);  // / ?
      8'h29: ascii = 8'h20;
      SC_ENTER: ascii = ASCII_CR;
      SC_BKSP:  ascii = ASCII_BS;
      8'h0D: ascii = ASCII_TAB;
      8'h76: ascii = ASCII_ESC;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_keycode_fifo.sv
// Set-2 scancode decoder with modifier tracking feeding a first-word-fall-through ASCII FIFO.
module ps2_keycode_fifo
  import ps2_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_cpu,
  input  logic          rst_n,
  input  logic [7:0]    scancode,
  input  logic          is_valid,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          shift_active,
  output logic          caps_lock
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  prefix_state_t state_q, state_d;
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic caps_q, caps_d, caps_held_q, caps_held_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic       make_ev, ext_ev, brk_ev;
  logic [7:0] xl_ascii;
  logic       xl_hit;
  logic       push, do_push, do_pop;
  logic [7:0] push_data;

  ps2_set2_to_ascii u_xlate (
    .code  (scancode),
    .shift (lshift_q | rshift_q),
    .caps  (caps_q),
    .ascii (xl_ascii),
    .hit   (xl_hit)
  );

  // Classify the current byte against the prefix state
  always_comb begin
    make_ev = is_valid && (state_q == ST_IDLE) && (scancode != SC_BREAK) && (scancode != SC_EXT);
    ext_ev  = is_valid && (state_q == ST_EXT) && (scancode != SC_BREAK);
    brk_ev  = is_valid && (state_q == ST_BRK);
    push      = 1'b0;
    push_data = 8'h00;
    if (make_ev && xl_hit) begin
      push      = 1'b1;
      push_data = xl_ascii;
    end else if (ext_ev && scancode == SC_ENTER) begin
      push      = 1'b1;
      push_data = ASCII_CR;
    end
  end

  // Prefix FSM next state
  always_comb begin
    state_d = state_q;
    if (is_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scancode == SC_BREAK)    state_d = ST_BRK;
          else if (scancode == SC_EXT) state_d = ST_EXT;
        end
        ST_EXT:  state_d = (scancode == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shift and Caps Lock tracking; caps_held suppresses typematic re-toggles
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (make_ev) begin
      if (scancode == SC_LSHIFT) lshift_d = 1'b1;
      if (scancode == SC_RSHIFT) rshift_d = 1'b1;
      if (scancode == SC_CAPS) begin
        if (!caps_held_q) caps_d = ~caps_q;
        caps_held_d = 1'b1;
      end
    end
    if (brk_ev) begin
      if (scancode == SC_LSHIFT) lshift_d = 1'b0;
      if (scancode == SC_RSHIFT) rshift_d = 1'b0;
      if (scancode == SC_CAPS)   caps_held_d = 1'b0;
    end
  end

  // FIFO pointer, count and sticky overflow update
  always_comb begin
    do_pop   = rd_en && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (push && !do_push) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;
  end

  // Control state registers
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO storage; contents are only observable through valid pointers
  always_ff @(posedge clk_cpu) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign rd_data      = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign shift_active = lshift_q | rshift_q;
  assign caps_lock    = caps_q;

endmodule

// File: tb/tb_ps2_keycode_fifo.sv
// Directed bench for ps2_keycode_fifo: scancode sequences with hand-computed ASCII results.
module tb_ps2_keycode_fifo;

  logic       clk_cpu = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       is_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, overflow, shift_active, caps_lock;
  logic [4:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  ps2_keycode_fifo #(.DEPTH(16)) dut (
    .clk_cpu      (clk_cpu),
    .rst_n        (rst_n),
    .scancode     (scancode),
    .is_valid     (is_valid),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .shift_active (shift_active),
    .caps_lock    (caps_lock)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte, valid for exactly one rising edge; returns at the following negedge
  task automatic send(input logic [7:0] b);
    @(negedge clk_cpu);
    scancode = b;
    is_valid = 1'b1;
    @(negedge clk_cpu);
    is_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk_cpu);
    rd_en = 1'b1;
    @(negedge clk_cpu);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_cpu);
    chk("rst_empty", 16'(empty), 16'h1);
    chk("rst_full", 16'(full), 16'h0);
    chk("rst_count", 16'(count), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    chk("rst_shift", 16'(shift_active), 16'h0);
    chk("rst_caps", 16'(caps_lock), 16'h0);
    chk("rst_rd_data", 16'(rd_data), 16'h0);
    rst_n = 1'b1;

    // 1C F0 1C -> single 'a', visible the cycle after the make byte
    send(8'h1C);
    chk("t1_latency_empty", 16'(empty), 16'h0);
    chk("t1_latency_data", 16'(rd_data), 16'h61);
    send(8'hF0); send(8'h1C);
    chk("t1_count", 16'(count), 16'h1);
    pop();
    chk("t1_drained", 16'(empty), 16'h1);

    // Shifted letter, release shift, unshifted digit
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h16);
    chk("t2_count", 16'(count), 16'h2);
    chk("t2_shift_off", 16'(shift_active), 16'h0);
    chk("t2_head0", 16'(rd_data), 16'h41);
    pop();
    chk("t2_head1", 16'(rd_data), 16'h31);
    pop();
    chk("t2_drained", 16'(empty), 16'h1);

    // Caps Lock typematic repeat toggles once; shift XOR caps for letters
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    chk("t3_caps", 16'(caps_lock), 16'h1);
    chk("t3_no_enqueue", 16'(count), 16'h0);
    send(8'h1C); send(8'h12); send(8'h1C);
    chk("t3_shift_on", 16'(shift_active), 16'h1);
    send(8'h12); send(8'h16);
    chk("t3_count", 16'(count), 16'h3);
    chk("t3_head0", 16'(rd_data), 16'h41);
    pop();
    chk("t3_head1", 16'(rd_data), 16'h61);
    pop();
    chk("t3_head2", 16'(rd_data), 16'h21);
    pop();
    send(8'hF0); send(8'h12);
    chk("t3_shift_off", 16'(shift_active), 16'h0);
    // second caps press toggles back
    send(8'h58); send(8'hF0); send(8'h58);
    chk("t3_caps_off", 16'(caps_lock), 16'h0);

    // Extended sequences: only E0 5A enqueues CR; FSM back in IDLE afterwards
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t4_ext_none", 16'(count), 16'h0);
    send(8'hE0); send(8'h5A);
    chk("t4_count", 16'(count), 16'h1);
    chk("t4_cr", 16'(rd_data), 16'h0D);
    send(8'h1C);
    chk("t4_idle_count", 16'(count), 16'h2);
    pop();
    chk("t4_idle_data", 16'(rd_data), 16'h61);
    pop();
    // break of E0 is swallowed, next byte is a plain make
    send(8'hF0); send(8'hE0); send(8'h29);
    chk("t4_brk_e0", 16'(rd_data), 16'h20);
    pop();

    // Fill past DEPTH
    for (int i = 0; i < 17; i++) send(8'h1C);
    chk("t5_full", 16'(full), 16'h1);
    chk("t5_count", 16'(count), 16'h10);
    chk("t5_ovf", 16'(overflow), 16'h1);
    // simultaneous push and pop while full
    @(negedge clk_cpu);
    scancode = 8'h1C; is_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk_cpu);
    is_valid = 1'b0; rd_en = 1'b0;
    chk("t5_pushpop_count", 16'(count), 16'h10);
    chk("t5_pushpop_full", 16'(full), 16'h1);
    // clear coinciding with a drop keeps the flag
    @(negedge clk_cpu);
    scancode = 8'h1C; is_valid = 1'b1; ovf_clr = 1'b1;
    @(negedge clk_cpu);
    is_valid = 1'b0; ovf_clr = 1'b0;
    chk("t5_clr_vs_drop", 16'(overflow), 16'h1);
    @(negedge clk_cpu);
    ovf_clr = 1'b1;
    @(negedge clk_cpu);
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", 16'(overflow), 16'h0);
    chk("t5_count_kept", 16'(count), 16'h10);
    // drain across the pointer wrap
    for (int i = 0; i < 16; i++) pop();
    chk("t5_drain_empty", 16'(empty), 16'h1);
    chk("t5_drain_count", 16'(count), 16'h0);
    // push and pop together while empty: push only
    @(negedge clk_cpu);
    scancode = 8'h16; is_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk_cpu);
    is_valid = 1'b0; rd_en = 1'b0;
    chk("t5_empty_pushpop", 16'(count), 16'h1);
    chk("t5_empty_pushpop_data", 16'(rd_data), 16'h31);

    // Reset mid-sequence clears shift, prefix and queued data
    send(8'h12); send(8'hE0);
    @(negedge clk_cpu);
    rst_n = 1'b0;
    @(negedge clk_cpu);
    chk("t6_rst_empty", 16'(empty), 16'h1);
    chk("t6_rst_shift", 16'(shift_active), 16'h0);
    rst_n = 1'b1;
    send(8'h1C);
    chk("t6_count", 16'(count), 16'h1);
    chk("t6_data", 16'(rd_data), 16'h61);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
